catalog_counter_param: RTL
==========================

// Module: catalog_counter_param
// PURPOSE
//   Parametrised synchronous up/down counter with parallel load, programmable modulus
//     and cascadable ripple-carry output.
//   Generalises the 4-bit catalog counter:
//     - adds direction control, wrap/saturate mode and load clamping;
//     - widens to WIDTH bits.
//   Used as a building block for timers and multi-digit counter chains (RCO -> next stage T).
// PARAMETERS
//   WIDTH    4     counter width in bits (1..32)
//   MODULUS  16    count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   SATURATE 0     0: wrap at terminal count; 1: hold at terminal count
// PORTS
//   CLK    in   1      rising-edge clock
//   CLR    in   1      asynchronous active-low reset
//   SCLR   in   1      synchronous clear, active-high
//   LOAD   in   1      synchronous parallel load, active-high
//   data   in   WIDTH  load value
//   P      in   1      count enable (local)
//   T      in   1      count enable (cascade); also gates RCO
//   UD     in   1      direction: 1 = up, 0 = down
//   Qdata  out  WIDTH  registered count
//   RCO    out  1      ripple carry out, combinational
//   TC     out  1      terminal-count flag, registered-state based, not gated by T
// BEHAVIOUR
//   - Reset: CLR low (async, any time) -> Qdata=0 immediately; held while CLR low.
//     Synchronous operation resumes at the first rising CLK after CLR deasserts.
//   - Priority on each rising CLK: SCLR > LOAD > count > hold.
//   - SCLR=1: Qdata<=0.
//   - LOAD=1:
//       Qdata <= data if data <= MODULUS-1;
//       Qdata <= MODULUS-1 if data > MODULUS-1 (clamp).
//     P/T are ignored during LOAD.
//   - Count: when P&T=1, Qdata steps by 1 in the UD direction.
//       Up at MODULUS-1:   SATURATE=0 -> 0;           SATURATE=1 -> hold MODULUS-1.
//       Down at 0:         SATURATE=0 -> MODULUS-1;   SATURATE=1 -> hold 0.
//   - Hold: P&T=0 -> Qdata unchanged.
//   - Terminal value depends on direction:
//       TERM = (UD ? MODULUS-1 : 0)
//       TC   = (Qdata == TERM)
//       RCO  = T & TC
//   - RCO/TC have zero latency to UD changes (combinational on UD, T, Qdata).
//   - Reset values: Qdata=0.
//       TC  = 1 if UD=0, else (MODULUS==1 never occurs) 0.
//       RCO = T & TC.
//   - Latency: LOAD/SCLR/count take effect on Qdata one CLK edge after sampling.
//   - Arithmetic: all comparisons are WIDTH-bit unsigned; MODULUS-1 is truncated to WIDTH bits.
//     MODULUS = 2**WIDTH gives natural binary wrap.
//   - Simultaneous events:
//       SCLR & LOAD -> clear;
//       LOAD & P&T  -> load;
//       UD toggled in the same cycle as count -> the new UD sampled at the edge decides direction.
// CONFIGURATION
//   - CATALOG_CNT_OVF_EN defined: adds output port OVF (out, 1).
//       OVF sets at the CLK edge where a count wraps (up past MODULUS-1 or down past 0)
//         with SATURATE=0, or where a count is blocked at terminal with SATURATE=1.
//       It is sticky until SCLR, LOAD, or CLR low; reset value 0.
//   - CATALOG_CNT_OVF_EN undefined: no OVF port and no OVF register; all other behaviour identical.
// TESTING
//   Bench uses WIDTH=4, MODULUS=10, SATURATE=0 unless noted; CLK period 100 ns.
//   1. CLR=0 mid-count (Qdata=7) -> Qdata=0 before the next CLK edge.
//      Release CLR, P=T=UD=1 -> 1,2,...
//   2. P=T=UD=1 from 0 for 12 edges -> 1..9,0,1,2.
//      RCO=1 only while Qdata=9.
//      OVF (if enabled) goes 1 after the 9->0 edge.
//   3. UD=0 from Qdata=2 -> 1,0,9,8.
//      RCO=1 only while Qdata=0 with T=1.
//      With T=0, RCO=0 and Qdata holds at 0.
//   4. LOAD=1, data=14 -> Qdata=9 (clamped).
//      LOAD=1, data=5, P=T=1 -> Qdata=5.
//      SCLR=1 with LOAD=1 -> Qdata=0.
//   5. SATURATE=1:
//        UD=1 from 8 -> 9,9,9;
//        UD=0 from 1 -> 0,0.
//      OVF (if enabled) sets on the first blocked edge; LOAD clears it.
//   6. Two instances cascaded: stage1.T = stage0.RCO, P=1, UD=1.
//      From 00, 25 edges -> stage1:stage0 = 2:5.

Source files
------------

// File: rtl/catalog_counter_param.sv
// catalog_counter_param
//   Parametrised synchronous up/down counter with parallel load (clamped to
//   the modulus), programmable modulus, wrap or saturate at terminal count,
//   and a cascadable ripple-carry output (RCO -> next stage T).
//
// Parameters
//   WIDTH     counter width in bits (1..32)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0: wrap at terminal count, 1: hold at terminal count
//
// Ports
//   CLK    in   rising-edge clock
//   CLR    in   asynchronous active-low reset
//   SCLR   in   synchronous clear (highest priority)
//   LOAD   in   synchronous parallel load of data (clamped to MODULUS-1)
//   data   in   load value
//   P, T   in   count enables (count when P & T); T also gates RCO
//   UD     in   direction, 1 = up, 0 = down
//   Qdata  out  registered count
//   RCO    out  ripple carry, T & TC (combinational)
//   TC     out  Qdata at the terminal value for the current direction
//   OVF    out  sticky wrap/blocked-count flag (only with CATALOG_CNT_OVF_EN)
//
// Build option
//   CATALOG_CNT_OVF_EN  when defined, adds the OVF output and its register.

module catalog_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] data,
  input  logic             P,
  input  logic             T,
  input  logic             UD,
  output logic [WIDTH-1:0] Qdata,
  output logic             RCO,
`ifdef CATALOG_CNT_OVF_EN
  output logic             TC,
  output logic             OVF
`else
  output logic             TC
`endif
);

  // MODULUS = 2**WIDTH truncates to all-ones, which gives natural binary wrap.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] q_next;
  logic             cnt_en;

  assign cnt_en = P & T;
  assign term   = UD ? MAXV : '0;
  assign TC     = (Qdata == term);
  assign RCO    = T & TC;

  always_comb begin
    q_next = Qdata;
    if (SCLR) begin
      q_next = '0;
    end else if (LOAD) begin
      q_next = (data > MAXV) ? MAXV : data;
    end else if (cnt_en) begin
      if (UD) begin
        if (Qdata == MAXV) q_next = (SATURATE != 0) ? MAXV : '0;
        else               q_next = Qdata + WIDTH'(1);
      end else begin
        if (Qdata == '0)   q_next = (SATURATE != 0) ? '0 : MAXV;
        else               q_next = Qdata - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) Qdata <= '0;
    else      Qdata <= q_next;
  end

`ifdef CATALOG_CNT_OVF_EN
  // A count attempted while already at the terminal value is exactly the
  // wrap (SATURATE=0) or blocked (SATURATE=1) case.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                    OVF <= 1'b0;
    else if (SCLR || LOAD)       OVF <= 1'b0;
    else if (cnt_en && TC)       OVF <= 1'b1;
  end
`endif

endmodule
